// File: rtl/nanov_sequencer_if.sv
// Fetch, core-timing and serial-memory signals of the nanoV sequencer.
// master: the sequencer. slave: the fetch/core/memory side.
interface nanov_sequencer_if;
  logic       instr_valid;
  logic [4:0] next_op;
  logic [2:0] next_funct3;
  logic       instr_take;
  logic       branch;
  logic       fetch_flush;
  logic [4:0] counter;
  logic [2:0] cycle;
  logic       core_en;
  logic       mem_req;
  logic       mem_ready;
  logic       shift_data_out;
  logic       mem_err;

  modport master (
    input  instr_valid, next_op, next_funct3, branch, mem_ready,
    output instr_take, fetch_flush, counter, cycle, core_en, mem_req,
           shift_data_out, mem_err
  );

  modport slave (
    output instr_valid, next_op, next_funct3, branch, mem_ready,
    input  instr_take, fetch_flush, counter, cycle, core_en, mem_req,
           shift_data_out, mem_err
  );
endinterface

// File: rtl/nanov_sequencer.sv
// nanoV sequencer: bit/pass timing for the bit-serial core, serial memory
// transfer window for loads and stores, and the fetch take/flush handshake.
// Optional build macro NANOV_SEQ_MEM_TIMEOUT_EN adds an idle timeout in MEM
// that aborts the transfer and raises a sticky mem_err.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_WAIT | idle, core stalled, waiting for instr_valid
// ST_EXEC | core running one 32-bit pass per 32 clocks
// ST_MEM  | core stalled, one data bit moved per mem_ready
module nanov_sequencer #(
  parameter int MEM_TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  nanov_sequencer_if.master bus
);

  typedef enum logic [1:0] {ST_WAIT, ST_EXEC, ST_MEM} state_e;
  typedef enum logic [2:0] {
    CLS_ALU, CLS_SHIFT, CLS_JMP, CLS_BRANCH, CLS_LOAD, CLS_STORE
  } cls_e;

  state_e     state;
  cls_e       cls;
  logic [4:0] counter_q;
  logic [2:0] cycle_q;
  logic       core_en_q;
  logic       mem_req_q;
  logic       branch_pend;
  logic [4:0] xfer_cnt;

  logic at_end, last_pass, is_mem_cls, xfer_done, timeout_hit, mem_end;
  logic complete, flush_now, take_now;

  function automatic cls_e decode(input logic [4:0] op, input logic [2:0] f3);
    case (op)
      5'b01100, 5'b00100: decode = (f3 == 3'b001 || f3 == 3'b101) ? CLS_SHIFT : CLS_ALU;
      5'b11011, 5'b11001: decode = CLS_JMP;
      5'b11000:           decode = CLS_BRANCH;
      5'b00000:           decode = CLS_LOAD;
      5'b01000:           decode = CLS_STORE;
      default:            decode = CLS_ALU;
    endcase
  endfunction

  function automatic logic [2:0] last_cycle_of(input cls_e c);
    case (c)
      CLS_ALU:  last_cycle_of = 3'd0;
      CLS_LOAD: last_cycle_of = 3'd2;
      default:  last_cycle_of = 3'd1;
    endcase
  endfunction

  // Completion, flush and take decisions for the current clock.
  always_comb begin
    at_end     = (state == ST_EXEC) && (counter_q == 5'd31);
    last_pass  = (cycle_q == last_cycle_of(cls));
    is_mem_cls = (cls == CLS_LOAD) || (cls == CLS_STORE);
    xfer_done  = (state == ST_MEM) && bus.mem_ready && (xfer_cnt == 5'd31);
    mem_end    = xfer_done || timeout_hit;
    complete   = (at_end && last_pass) || (mem_end && cls == CLS_STORE);
    // A pending or same-clock branch wins over a waiting instruction.
    flush_now  = complete && (branch_pend || bus.branch);
    take_now   = !rst && bus.instr_valid &&
                 ((state == ST_WAIT) || (complete && !flush_now));
  end

  // Main sequencing FSM with registered core timing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_WAIT;
      cls         <= CLS_ALU;
      counter_q   <= 5'd0;
      cycle_q     <= 3'd0;
      core_en_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      branch_pend <= 1'b0;
      xfer_cnt    <= 5'd0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (bus.instr_valid) begin
            state     <= ST_EXEC;
            cls       <= decode(bus.next_op, bus.next_funct3);
            core_en_q <= 1'b1;
            counter_q <= 5'd0;
            cycle_q   <= 3'd0;
          end
        end
        ST_EXEC: begin
          counter_q <= counter_q + 5'd1;
          if (bus.branch) branch_pend <= 1'b1;
          if (at_end && !last_pass) begin
            cycle_q <= cycle_q + 3'd1;
            if (is_mem_cls && cycle_q == 3'd0) begin
              state     <= ST_MEM;
              core_en_q <= 1'b0;
              mem_req_q <= 1'b1;
              xfer_cnt  <= 5'd0;
            end
          end
        end
        ST_MEM: begin
          if (bus.mem_ready) xfer_cnt <= xfer_cnt + 5'd1;
          if (mem_end && cls == CLS_LOAD) begin
            state     <= ST_EXEC;
            core_en_q <= 1'b1;
            mem_req_q <= 1'b0;
            cycle_q   <= 3'd2;
            xfer_cnt  <= 5'd0;
          end
        end
        default: state <= ST_WAIT;
      endcase

      // Instruction completion overrides the per-state updates above.
      if (complete) begin
        branch_pend <= 1'b0;
        counter_q   <= 5'd0;
        cycle_q     <= 3'd0;
        mem_req_q   <= 1'b0;
        xfer_cnt    <= 5'd0;
        if (take_now) begin
          state     <= ST_EXEC;
          cls       <= decode(bus.next_op, bus.next_funct3);
          core_en_q <= 1'b1;
        end else begin
          state     <= ST_WAIT;
          core_en_q <= 1'b0;
        end
      end
    end
  end

`ifdef NANOV_SEQ_MEM_TIMEOUT_EN
  logic [7:0] idle_cnt;
  logic       mem_err_q;

  assign timeout_hit = (state == ST_MEM) && !bus.mem_ready &&
                       (idle_cnt == 8'(MEM_TIMEOUT - 1));

  // Idle clock counter in MEM; held at zero outside MEM so entry starts clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt  <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      if (state != ST_MEM || bus.mem_ready) idle_cnt <= 8'd0;
      else                                  idle_cnt <= idle_cnt + 8'd1;
      if (timeout_hit) mem_err_q <= 1'b1;
    end
  end

  assign bus.mem_err = mem_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.mem_err = 1'b0;
`endif

  assign bus.counter        = counter_q;
  assign bus.cycle          = cycle_q;
  assign bus.core_en        = core_en_q;
  assign bus.mem_req        = mem_req_q;
  assign bus.instr_take     = take_now;
  assign bus.fetch_flush    = !rst && flush_now;
  assign bus.shift_data_out = !rst && (state == ST_MEM) && bus.mem_ready;

endmodule

// File: tb/tb_nanov_sequencer.sv
// Testbench for nanov_sequencer: instruction-class table run with a
// scoreboard, plus hand sequences for memory, branch, reset and timeout.
module tb_nanov_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nanov_sequencer_if bus();
  nanov_sequencer #(.MEM_TIMEOUT(255)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [4:0] op;
    logic [2:0] f3;
    int         exec_clk;
    int         mem_clk;
    bit         is_load;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl[NV];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   err_seen = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic finalize(input int e, input int m, input int sh, input int tot,
                          input bit cnt_ok, input bit cyc_ok);
    vec_t x;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 0, 1);
      return;
    end
    x = sb.pop_front();
    check($sformatf("exec_clocks op=%b", x.op), e, x.exec_clk);
    check($sformatf("mem_clocks op=%b", x.op), m, x.mem_clk);
    check($sformatf("shift_pulses op=%b", x.op), sh, x.mem_clk);
    check($sformatf("instr_length op=%b", x.op), tot, x.exec_clk + x.mem_clk);
    check($sformatf("counter_seq op=%b", x.op), int'(cnt_ok), 1);
    check($sformatf("cycle_seq op=%b", x.op), int'(cyc_ok), 1);
  endtask

  // Back-to-back run over the table with instr_valid always high and
  // mem_ready always high while in MEM.
  task automatic run_table();
    int idx = 0, cyc = 0, e = 0, m = 0, sh = 0, tot = 0, idle_ends = 0, exp_cyc;
    bit busy = 1'b0, cnt_ok = 1'b1, cyc_ok = 1'b1;
    vec_t cur;
    while ((idx < NV || busy) && cyc < 6000) begin
      @(negedge clk);
      if (idx < NV) begin
        bus.instr_valid = 1'b1;
        bus.next_op     = tbl[idx].op;
        bus.next_funct3 = tbl[idx].f3;
      end else begin
        bus.instr_valid = 1'b0;
      end
      bus.mem_ready = 1'b1;
      bus.branch    = 1'b0;
      #1;
      cyc++;
      if (bus.mem_err) err_seen = 1'b1;
      if (busy) begin
        if (!bus.core_en && !bus.mem_req) begin
          finalize(e, m, sh, tot, cnt_ok, cyc_ok);
          busy = 1'b0;
          idle_ends++;
        end else begin
          tot++;
          if (bus.core_en) begin
            exp_cyc = (cur.is_load && (e / 32) == 1) ? 2 : e / 32;
            if (int'(bus.counter) != e % 32) cnt_ok = 1'b0;
            if (int'(bus.cycle) != exp_cyc) cyc_ok = 1'b0;
            e++;
          end
          if (bus.mem_req) begin
            m++;
            if (bus.counter != 5'd0 || bus.cycle != 3'd1 || bus.core_en) cnt_ok = 1'b0;
          end
          if (bus.shift_data_out) sh++;
        end
      end
      if (bus.instr_take) begin
        if (busy) finalize(e, m, sh, tot, cnt_ok, cyc_ok);
        if (idx < NV) begin
          cur = tbl[idx];
          sb.push_back(tbl[idx]);
          idx++;
        end else begin
          check("spurious_take", 1, 0);
        end
        busy = 1'b1; e = 0; m = 0; sh = 0; tot = 0; cnt_ok = 1'b1; cyc_ok = 1'b1;
      end
    end
    check("table_in_budget", int'(cyc < 6000), 1);
    check("table_all_taken", idx, NV);
    check("table_no_gaps", idle_ends, 1);
    check("table_sb_empty", sb.size(), 0);
  endtask

  // One instruction from WAIT to WAIT; optional 1,0,1,... mem_ready pattern.
  task automatic run_single(input logic [4:0] op, input logic [2:0] f3, input bit toggle,
                            output int e, output int m, output int sh, output int cyc_after);
    bit started = 1'b0, ph = 1'b1, was_mem = 1'b0, ended = 1'b0;
    int cyc = 0;
    e = 0; m = 0; sh = 0; cyc_after = -1;
    while (!ended && cyc < 1000) begin
      @(negedge clk);
      bus.instr_valid = !started;
      bus.next_op     = op;
      bus.next_funct3 = f3;
      bus.branch      = 1'b0;
      if (bus.mem_req) begin
        bus.mem_ready = toggle ? ph : 1'b1;
        ph = !ph;
      end else begin
        bus.mem_ready = 1'b0;
      end
      #1;
      cyc++;
      if (started) begin
        if (!bus.core_en && !bus.mem_req) ended = 1'b1;
        else begin
          if (bus.core_en) begin
            e++;
            if (was_mem && cyc_after < 0) cyc_after = int'(bus.cycle);
          end
          if (bus.mem_req) begin m++; was_mem = 1'b1; end
          if (bus.shift_data_out) sh++;
        end
      end
      if (bus.instr_take) started = 1'b1;
    end
    check("single_in_budget", int'(ended), 1);
  endtask

  // Branch strobe at clock bclk after the take of a 2-pass instruction,
  // with an ADDI waiting behind it.
  task automatic branch_test(input logic [4:0] op, input int bclk);
    bit st = 1'b0;
    int guard = 0, early = 0;
    while (!st && guard < 10) begin
      @(negedge clk);
      guard++;
      bus.instr_valid = 1'b1; bus.next_op = op; bus.next_funct3 = 3'b000;
      bus.branch = 1'b0; bus.mem_ready = 1'b0;
      #1;
      if (bus.instr_take) st = 1'b1;
    end
    check("br_first_take", int'(st), 1);
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      bus.instr_valid = 1'b1; bus.next_op = 5'b00100; bus.next_funct3 = 3'b000;
      bus.branch = (k == bclk);
      #1;
      if (k < 64) begin
        if (bus.fetch_flush || bus.instr_take) early++;
      end else begin
        check($sformatf("br_flush bclk=%0d", bclk), int'(bus.fetch_flush), 1);
        check($sformatf("br_no_take bclk=%0d", bclk), int'(bus.instr_take), 0);
      end
    end
    check($sformatf("br_early_events bclk=%0d", bclk), early, 0);
    @(negedge clk);
    bus.branch = 1'b0;
    #1;
    check("br_wait_core_en", int'(bus.core_en), 0);
    check("br_wait_take", int'(bus.instr_take), 1);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    #1;
    check("br_new_exec", int'(bus.core_en), 1);
    check("br_new_counter", int'(bus.counter), 0);
    guard = 0;
    while (bus.core_en && guard < 40) begin
      @(negedge clk); #1; guard++;
    end
    check("br_drain", int'(bus.core_en), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_counter"}, int'(bus.counter), 0);
    check({tag, "_cycle"}, int'(bus.cycle), 0);
    check({tag, "_core_en"}, int'(bus.core_en), 0);
    check({tag, "_mem_req"}, int'(bus.mem_req), 0);
    check({tag, "_instr_take"}, int'(bus.instr_take), 0);
    check({tag, "_fetch_flush"}, int'(bus.fetch_flush), 0);
    check({tag, "_shift"}, int'(bus.shift_data_out), 0);
    check({tag, "_mem_err"}, int'(bus.mem_err), 0);
  endtask

  initial begin
    int e, m, sh, ca, mc, guard;
    bit st;
    tbl[0]  = '{5'b00100, 3'b000, 32, 0, 1'b0};  // ADDI
    tbl[1]  = '{5'b00100, 3'b001, 64, 0, 1'b0};  // SLLI
    tbl[2]  = '{5'b01100, 3'b000, 32, 0, 1'b0};  // ADD
    tbl[3]  = '{5'b01100, 3'b101, 64, 0, 1'b0};  // SRA
    tbl[4]  = '{5'b01101, 3'b011, 32, 0, 1'b0};  // LUI
    tbl[5]  = '{5'b00101, 3'b001, 32, 0, 1'b0};  // AUIPC
    tbl[6]  = '{5'b11011, 3'b000, 64, 0, 1'b0};  // JAL
    tbl[7]  = '{5'b11001, 3'b000, 64, 0, 1'b0};  // JALR
    tbl[8]  = '{5'b11000, 3'b000, 64, 0, 1'b0};  // BEQ, not taken
    tbl[9]  = '{5'b00000, 3'b010, 64, 32, 1'b1}; // LW
    tbl[10] = '{5'b01000, 3'b010, 32, 32, 1'b0}; // SW
    tbl[11] = '{5'b00011, 3'b000, 32, 0, 1'b0};  // FENCE -> ALU
    tbl[12] = '{5'b11100, 3'b001, 32, 0, 1'b0};  // SYSTEM f3=001 -> ALU
    tbl[13] = '{5'b00100, 3'b101, 64, 0, 1'b0};  // SRLI

    rst = 1'b1;
    bus.instr_valid = 1'b0; bus.next_op = 5'd0; bus.next_funct3 = 3'd0;
    bus.branch = 1'b0; bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    run_table();
    check("no_mem_err_in_table", int'(err_seen), 0);

    run_single(5'b00000, 3'b010, 1'b1, e, m, sh, ca);
    check("lw_toggle_exec", e, 64);
    check("lw_toggle_mem_req", m, 63);
    check("lw_toggle_shifts", sh, 32);
    check("lw_toggle_cycle_after_mem", ca, 2);

    branch_test(5'b11000, 32);
    branch_test(5'b11011, 64);

    // Reset in the middle of a store transfer, after 17 bits.
    mc = 0; st = 1'b0; guard = 0;
    while (guard < 200 && mc < 17) begin
      @(negedge clk);
      guard++;
      bus.instr_valid = !st; bus.next_op = 5'b01000; bus.next_funct3 = 3'b010;
      bus.branch = 1'b0; bus.mem_ready = 1'b1;
      #1;
      if (st && bus.mem_req) mc++;
      if (bus.instr_take) st = 1'b1;
    end
    check("rst_mid_mem_reached", mc, 17);
    @(negedge clk);
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    #1;
    check_all_zero("rst_mid_mem");
    rst = 1'b0;
    run_single(5'b01000, 3'b010, 1'b0, e, m, sh, ca);
    check("sw_after_rst_exec", e, 32);
    check("sw_after_rst_mem", m, 32);
    check("sw_after_rst_shifts", sh, 32);

`ifdef NANOV_SEQ_MEM_TIMEOUT_EN
    // Store with mem_ready stuck low; an ADDI waits behind it.
    mc = 0; st = 1'b0; guard = 0;
    begin
      bit done = 1'b0;
      int take_mc = -1;
      while (!done && guard < 600) begin
        @(negedge clk);
        guard++;
        bus.instr_valid = 1'b1;
        bus.next_op     = st ? 5'b00100 : 5'b01000;
        bus.next_funct3 = st ? 3'b000 : 3'b010;
        bus.branch = 1'b0; bus.mem_ready = 1'b0;
        #1;
        if (st && bus.mem_req) mc++;
        if (bus.instr_take && st) begin take_mc = mc; done = 1'b1; end
        else if (bus.instr_take) st = 1'b1;
      end
      check("to_mem_clocks_at_take", take_mc, 255);
      check("to_err_not_yet", int'(bus.mem_err), 0);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    #1;
    check("to_mem_err_set", int'(bus.mem_err), 1);
    check("to_next_exec", int'(bus.core_en), 1);
    check("to_mem_req_off", int'(bus.mem_req), 0);
    repeat (5) @(negedge clk);
    #1;
    check("to_mem_err_sticky", int'(bus.mem_err), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("to_mem_err_rst", int'(bus.mem_err), 0);
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/nanov_sequencer.md
# nanoV_sequencer

Sequencer for the bit-serial nanoV core. It produces the `counter`/`cycle` timing the core runs on and decides how many 32-bit passes each instruction needs. It runs the serial memory-transfer window for loads and stores and hands off to instruction fetch with a valid/take handshake. It sits between the fetch/memory interface and the core.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: clocks `mem_ready` may stay low in MEM before abort. Used only with the timeout feature.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid` in 1: fetch holds a complete next instruction.
- `next_op` in 5: `next_instr[6:2]` of that instruction.
- `next_funct3` in 3: `next_instr[14:12]`.
- `instr_take` out 1: one-clock pulse; fetch consumes the instruction and the core latches it.
- `branch` in 1: core branch/jump-taken strobe.
- `fetch_flush` out 1: one-clock pulse with `instr_take` slot; fetch restarts at the new PC.
- `counter` out 5: bit index to core.
- `cycle` out 3: pass index to core.
- `core_en` out 1: clock-enable for core register/ALU state.
- `mem_req` out 1: memory transfer in progress.
- `mem_ready` in 1: one data bit transferred this clock.
- `shift_data_out` out 1: core data shift strobe.
- `mem_err` out 1: timeout abort flag (timeout build only, else tied 0).

## Operation
- Latched class from `next_op`/`next_funct3` on take:
  - ALU: OP, OP-IMM non-shift, LUI, AUIPC. Passes = 1.
  - SHIFT: OP/OP-IMM with funct3 001 or 101. Passes = 2.
  - JMP: JAL, JALR. Passes = 2.
  - BRANCH. Passes = 2.
  - LOAD: cycle 0 exec, cycle 1 MEM, cycle 2 exec. Last cycle = 2.
  - STORE: cycle 0 exec, cycle 1 MEM. Last cycle = 1.
  - Any other opcode is treated as ALU.
- States: WAIT, EXEC, MEM.
- WAIT:
  - `core_en`=0, `counter`=0, `cycle`=0.
  - When `instr_valid`=1: pulse `instr_take`, latch the class, go to EXEC next clock.
- EXEC:
  - `core_en`=1; `counter` increments every clock and wraps 31→0.
  - At `counter`==31 with `cycle` below last cycle: `cycle`+1. Go to MEM if the new pass is a memory pass, else stay in EXEC.
  - At `counter`==31 with `cycle`==last cycle, the instruction completes:
    - If `branch_pend` is set, or `branch`=1 this clock: pulse `fetch_flush`, go to WAIT, clear `branch_pend`.
    - Else if `instr_valid`=1: pulse `instr_take`, latch the new class, stay in EXEC with `cycle`=0.
    - Else go to WAIT.
- `branch` in EXEC sets `branch_pend` (sticky until completion).
- MEM:
  - `core_en`=0, `mem_req`=1, `counter` held at 0, `cycle`=1, `shift_data_out`=`mem_ready`.
  - A 5-bit transfer count increments on each `mem_ready`.
  - When `mem_ready` arrives with count 31, the transfer is done:
    - LOAD: go to EXEC with `cycle`=2.
    - STORE: complete exactly as at end of EXEC, including the `instr_valid` and flush check.
- Simultaneous events:
  - Completion with `instr_valid`=1 and a branch pending: flush wins. `instr_take`=0, the valid instruction is discarded by fetch on `fetch_flush`.
- Reset at any point:
  - State WAIT, transfer count 0, `branch_pend`=0.
  - All outputs 0 next clock; an in-flight MEM transfer is abandoned.

## Timing
- Reset values: `counter`=0, `cycle`=0, `core_en`=0, `instr_take`=0, `fetch_flush`=0, `mem_req`=0, `shift_data_out`=0, `mem_err`=0.
- WAIT → first EXEC bit: 1 clock after `instr_valid` seen.
- Back-to-back instructions with no wait states:
  - ALU: 32 clocks.
  - SHIFT/JMP/BRANCH: 64 clocks.
  - STORE: 32 + 32 transfer clocks.
  - LOAD: 64 + 32 transfer clocks.
- `mem_req` is asserted the clock after the `counter`==31 that ends cycle 0, and deasserts the clock after the 32nd `mem_ready`.
- `counter`, `cycle`, `core_en`, `mem_req` and `mem_err` are registered. `instr_take`, `fetch_flush` and `shift_data_out` are combinational from state and inputs.

## Configuration
- `NANOV_SEQ_MEM_TIMEOUT_EN` defined:
  - An 8-bit idle counter in MEM resets on every `mem_ready` and on entry to MEM.
  - Reaching `MEM_TIMEOUT` sets sticky `mem_err`, which clears only on `rst`, and ends the transfer. LOAD goes to EXEC cycle 2 with whatever data is shifted; STORE completes.
- Not defined: no idle counter, MEM waits indefinitely, `mem_err` is constant 0.

## Test plan
- Reset, then `instr_valid`=1 with ADDI → `instr_take` pulse, 32 EXEC clocks with `counter` 0..31 and `cycle`=0, then the next take on clock 33.
- SLLI followed immediately by ADD, `instr_valid` always 1 → `cycle` 0 then 1 across 64 clocks; the second `instr_take` is at the end of `cycle` 1.
- LW with `mem_ready` toggling 1,0,1,… → `mem_req` high for 63 clocks, exactly 32 `shift_data_out` pulses, then EXEC `cycle`=2.
- BEQ with `branch`=1 at `cycle` 0, `counter` 31, and `instr_valid`=1 → at completion `fetch_flush`=1, `instr_take`=0, state WAIT.
- `rst` asserted mid-MEM at transfer count 17 → next clock all outputs 0; a fresh SW then performs a full 32-bit transfer.
- Timeout build, SW with `mem_ready` stuck at 0 → `mem_err`=1 after 255 MEM clocks and the next instruction is taken.
